gradient_descent_scheduler: RTL and testbench

Sequences weight updates for one layer by driving the single-cycle gradient-descent update unit.
- Walks a contiguous range of weight addresses.
- Reads the old weight and its gradient from synchronous-read buffers.
- Issues one update per weight to the update unit and waits for its done.
- Writes the updated weight back, then signals completion.
- Sits between the training control FSM and the weight/gradient buffers.

---
 rtl/gradient_descent_scheduler_if.sv | 47 ++++
 rtl/gradient_descent_scheduler.sv | 142 ++++++++++++++
 tb/tb_gradient_descent_scheduler.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gradient_descent_scheduler_if.sv
`default_nettype none
// =============================================================================
// gradient_descent_scheduler_if : training-control, buffer and update-unit
// signals seen by the gradient-descent weight-update scheduler.
// Revision: 1.0
// =============================================================================
interface gradient_descent_scheduler_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              start_in;
    logic [ADDR_W:0]   len_in;
    logic [DATA_W-1:0] lr_in;
    logic              rd_en_out;
    logic [ADDR_W-1:0] rd_addr_out;
    logic [DATA_W-1:0] rd_w_data_in;
    logic [DATA_W-1:0] rd_g_data_in;
    logic              gd_start_out;
    logic [DATA_W-1:0] gd_lr_out;
    logic [DATA_W-1:0] gd_W_old_out;
    logic [DATA_W-1:0] gd_grad_out;
    logic              gd_done_in;
    logic [DATA_W-1:0] gd_W_updated_in;
    logic              wr_en_out;
    logic [ADDR_W-1:0] wr_addr_out;
    logic [DATA_W-1:0] wr_data_out;
    logic              busy_out;
    logic              done_out;

    // The scheduler is the master: it drives the buffers and the update unit.
    modport master (
        input  start_in, len_in, lr_in, rd_w_data_in, rd_g_data_in,
               gd_done_in, gd_W_updated_in,
        output rd_en_out, rd_addr_out, gd_start_out, gd_lr_out, gd_W_old_out,
               gd_grad_out, wr_en_out, wr_addr_out, wr_data_out, busy_out,
               done_out
    );

    modport slave (
        output start_in, len_in, lr_in, rd_w_data_in, rd_g_data_in,
               gd_done_in, gd_W_updated_in,
        input  rd_en_out, rd_addr_out, gd_start_out, gd_lr_out, gd_W_old_out,
               gd_grad_out, wr_en_out, wr_addr_out, wr_data_out, busy_out,
               done_out
    );
endinterface
`default_nettype wire

// File: rtl/gradient_descent_scheduler.sv
`default_nettype none
// =============================================================================
// gradient_descent_scheduler : walks a weight range, feeding each weight and
// gradient to the update unit and writing the result back in order.
// Revision: 1.0
// =============================================================================
module gradient_descent_scheduler #(
    parameter int NUM_WEIGHTS = 16,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 16
) (
    input  logic clk,
    input  logic rst,
    gradient_descent_scheduler_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_ISSUE   = 3'd3,
        S_WAIT    = 3'd4,
        S_WRITE   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [ADDR_W:0] c_MAX_LEN = (ADDR_W+1)'(NUM_WEIGHTS);
    localparam logic [ADDR_W:0] c_ONE     = (ADDR_W+1)'(1);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W:0]   r_len;
    logic [DATA_W-1:0] r_lr;
    logic [DATA_W-1:0] r_w_old;
    logic [DATA_W-1:0] r_grad;
    logic [DATA_W-1:0] r_wr_data;
    logic [ADDR_W:0]   w_len_clamped;
    logic              w_last;

    assign w_len_clamped = (bus.len_in > c_MAX_LEN) ? c_MAX_LEN : bus.len_in;
    // r_len is at least 1 whenever WRITE is reached, so len-1 cannot underflow.
    assign w_last        = ({1'b0, r_idx} == (r_len - c_ONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        bus.rd_en_out    = 1'b0;
        bus.gd_start_out = 1'b0;
        bus.wr_en_out    = 1'b0;
        bus.busy_out     = 1'b1;
        bus.done_out     = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.busy_out = 1'b0;
                if (bus.start_in) begin
                    w_next_state = (w_len_clamped == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                bus.rd_en_out = 1'b1;
                w_next_state  = S_CAPTURE;
            end
            S_CAPTURE: w_next_state = S_ISSUE;
            S_ISSUE: begin
                bus.gd_start_out = 1'b1;
                w_next_state     = S_WAIT;
            end
            S_WAIT: begin
                if (bus.gd_done_in) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                bus.wr_en_out = 1'b1;
                w_next_state  = w_last ? S_DONE : S_READ;
            end
            S_DONE: begin
                bus.done_out = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                bus.busy_out = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= '0;
            r_len     <= '0;
            r_lr      <= '0;
            r_w_old   <= '0;
            r_grad    <= '0;
            r_wr_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_in) begin
                        r_lr  <= bus.lr_in;
                        r_len <= w_len_clamped;
                        r_idx <= '0;
                    end
                end
                S_CAPTURE: begin
                    r_w_old <= bus.rd_w_data_in;
                    r_grad  <= bus.rd_g_data_in;
                end
                S_WAIT: begin
                    if (bus.gd_done_in) begin
                        r_wr_data <= bus.gd_W_updated_in;
                    end
                end
                S_WRITE: begin
                    if (!w_last) begin
                        r_idx <= r_idx + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read and write share one index: each write lands before the next read.
    assign bus.rd_addr_out  = r_idx;
    assign bus.wr_addr_out  = r_idx;
    assign bus.gd_lr_out    = r_lr;
    assign bus.gd_W_old_out = r_w_old;
    assign bus.gd_grad_out  = r_grad;
    assign bus.wr_data_out  = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_gradient_descent_scheduler.sv
`default_nettype none
// =============================================================================
// tb_gradient_descent_scheduler : directed bench with buffer and update-unit
// models for the gradient-descent scheduler.
// Revision: 1.0
// =============================================================================
module tb_gradient_descent_scheduler;

    localparam int NW = 16;
    localparam int AW = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gradient_descent_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) sif ();

    gradient_descent_scheduler #(
        .NUM_WEIGHTS(NW),
        .ADDR_W     (AW),
        .DATA_W     (DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

    logic [DW-1:0] wmem [NW];
    logic [DW-1:0] gmem [NW];
    int vectors     = 0;
    int miscompares = 0;
    int gd_delay    = 0;
    int gd_cnt;
    logic gd_pending;
    logic [DW-1:0] gd_res;

    // Synchronous-read weight and gradient buffers
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sif.rd_w_data_in <= '0;
            sif.rd_g_data_in <= '0;
        end else if (sif.rd_en_out) begin
            sif.rd_w_data_in <= wmem[sif.rd_addr_out];
            sif.rd_g_data_in <= gmem[sif.rd_addr_out];
        end
    end

    // Update unit: W - lr*G, done one cycle after start plus gd_delay extra cycles
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sif.gd_done_in      <= 1'b0;
            sif.gd_W_updated_in <= '0;
            gd_pending          <= 1'b0;
            gd_cnt              <= 0;
            gd_res              <= '0;
        end else begin
            sif.gd_done_in <= 1'b0;
            if (sif.gd_start_out) begin
                if (gd_delay == 0) begin
                    sif.gd_done_in      <= 1'b1;
                    sif.gd_W_updated_in <= sif.gd_W_old_out - DW'(sif.gd_lr_out * sif.gd_grad_out);
                end else begin
                    gd_pending <= 1'b1;
                    gd_cnt     <= gd_delay - 1;
                    gd_res     <= sif.gd_W_old_out - DW'(sif.gd_lr_out * sif.gd_grad_out);
                end
            end else if (gd_pending) begin
                if (gd_cnt == 0) begin
                    sif.gd_done_in      <= 1'b1;
                    sif.gd_W_updated_in <= gd_res;
                    gd_pending          <= 1'b0;
                end else begin
                    gd_cnt <= gd_cnt - 1;
                end
            end
        end
    end

    int cyc = 0;
    int n_start = 0;
    int last_done_cyc = 0;
    int last_wr_cyc = 0;
    logic [AW-1:0] rd_addr_q [$];
    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sif.gd_start_out) n_start <= n_start + 1;
        if (sif.rd_en_out) rd_addr_q.push_back(sif.rd_addr_out);
        if (sif.gd_done_in) last_done_cyc <= cyc;
        if (sif.wr_en_out) begin
            wr_addr_q.push_back(sif.wr_addr_out);
            wr_data_q.push_back(sif.wr_data_out);
            last_wr_cyc <= cyc;
        end
    end

    task automatic start_run(input logic [AW:0] len, input logic [DW-1:0] lr);
        @(negedge clk);
        sif.start_in = 1'b1;
        sif.len_in   = len;
        sif.lr_in    = lr;
        @(negedge clk);
        sif.start_in = 1'b0;
    endtask

    // k = index of the first negedge (1 = the one right after the start edge) showing done
    task automatic wait_done(input int budget, output int k, output int busy_lows);
        k = -1;
        busy_lows = 0;
        for (int i = 1; i <= budget; i++) begin
            if (i > 1) @(negedge clk);
            if (sif.done_out === 1'b1) begin
                k = i;
                break;
            end
            if (sif.busy_out !== 1'b1) busy_lows++;
        end
    endtask

    task automatic load_sweep();
        for (int i = 0; i < NW; i++) begin
            wmem[i] = 16'h0100 + DW'(i);
            gmem[i] = 16'h0001;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sif.start_in = 1'b0;
        sif.len_in   = '0;
        sif.lr_in    = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({sif.rd_en_out, sif.gd_start_out, sif.wr_en_out, sif.busy_out, sif.done_out} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {sif.rd_en_out, sif.gd_start_out, sif.wr_en_out, sif.busy_out, sif.done_out});
        end
        vectors++;
        if ({sif.rd_addr_out, sif.wr_addr_out, sif.gd_lr_out, sif.gd_W_old_out, sif.gd_grad_out, sif.wr_data_out} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got lr=%h wold=%h grad=%h wdata=%h raddr=%h waddr=%h want all 0",
                     sif.gd_lr_out, sif.gd_W_old_out, sif.gd_grad_out, sif.wr_data_out,
                     sif.rd_addr_out, sif.wr_addr_out);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (sif.busy_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_busy: got %b want 0", sif.busy_out);
        end
    endtask

    task automatic test_basic();
        int k, bl, wb, sb;
        wmem[0] = 16'h0010;
        gmem[0] = 16'h0002;
        wb = wr_addr_q.size();
        sb = n_start;
        start_run(5'd1, 16'h0003);
        wait_done(50, k, bl);
        vectors++;
        if (k !== 6) begin miscompares++; $display("FAIL basic_done_cycle: got %0d want 6", k); end
        vectors++;
        if (wr_addr_q.size() - wb !== 1) begin
            miscompares++; $display("FAIL basic_write_count: got %0d want 1", wr_addr_q.size() - wb);
        end else begin
            vectors++;
            if (wr_addr_q[wb] !== 4'd0 || wr_data_q[wb] !== 16'h000A) begin
                miscompares++;
                $display("FAIL basic_write: got addr=%h data=%h want addr=0 data=000a", wr_addr_q[wb], wr_data_q[wb]);
            end
        end
        vectors++;
        if (sif.gd_lr_out !== 16'h0003) begin miscompares++; $display("FAIL basic_lr: got %h want 0003", sif.gd_lr_out); end
        @(negedge clk);
        vectors++;
        if ({sif.done_out, sif.busy_out} !== 2'b00 || n_start - sb !== 1) begin
            miscompares++;
            $display("FAIL basic_end: got done=%b busy=%b starts=%0d want 0 0 1", sif.done_out, sif.busy_out, n_start - sb);
        end
    endtask

    task automatic test_full_sweep();
        int k, bl, wb, sb, n;
        load_sweep();
        wb = wr_addr_q.size();
        sb = n_start;
        start_run(5'd16, 16'h0001);
        wait_done(200, k, bl);
        vectors++;
        if (k !== 81) begin miscompares++; $display("FAIL sweep_done_cycle: got %0d want 81", k); end
        vectors++;
        if (bl !== 0) begin miscompares++; $display("FAIL sweep_busy: got %0d low cycles want 0", bl); end
        vectors++;
        if (n_start - sb !== 16) begin miscompares++; $display("FAIL sweep_starts: got %0d want 16", n_start - sb); end
        n = wr_addr_q.size() - wb;
        vectors++;
        if (n !== 16) begin miscompares++; $display("FAIL sweep_write_count: got %0d want 16", n); end
        for (int i = 0; i < n && i < 16; i++) begin
            vectors++;
            if (wr_addr_q[wb+i] !== AW'(i) || wr_data_q[wb+i] !== 16'h00FF + DW'(i)) begin
                miscompares++;
                $display("FAIL sweep_write[%0d]: got addr=%h data=%h want addr=%h data=%h",
                         i, wr_addr_q[wb+i], wr_data_q[wb+i], AW'(i), 16'h00FF + DW'(i));
            end
        end
    endtask

    task automatic test_back_pressure();
        int k, bl, wb, sb;
        wmem[0] = 16'h0020;
        gmem[0] = 16'h0003;
        gd_delay = 4;
        wb = wr_addr_q.size();
        sb = n_start;
        start_run(5'd1, 16'h0002);
        wait_done(50, k, bl);
        vectors++;
        if (k !== 10) begin miscompares++; $display("FAIL bp_done_cycle: got %0d want 10", k); end
        vectors++;
        if (last_wr_cyc !== last_done_cyc + 1) begin
            miscompares++; $display("FAIL bp_write_timing: got wr@%0d done@%0d want wr = done+1", last_wr_cyc, last_done_cyc);
        end
        vectors++;
        if (n_start - sb !== 1) begin miscompares++; $display("FAIL bp_starts: got %0d want 1", n_start - sb); end
        vectors++;
        if (wr_addr_q.size() - wb !== 1 || wr_data_q[wr_data_q.size()-1] !== 16'h001A) begin
            miscompares++;
            $display("FAIL bp_write: got count=%0d data=%h want 1 001a", wr_addr_q.size() - wb, wr_data_q[wr_data_q.size()-1]);
        end
        gd_delay = 0;
        @(negedge clk);
    endtask

    task automatic test_len_zero();
        int k, bl, wb, rb, sb;
        wb = wr_addr_q.size();
        rb = rd_addr_q.size();
        sb = n_start;
        start_run(5'd0, 16'h0005);
        wait_done(20, k, bl);
        vectors++;
        if (k !== 1) begin miscompares++; $display("FAIL zero_done_cycle: got %0d want 1", k); end
        @(negedge clk);
        vectors++;
        if (rd_addr_q.size() - rb !== 0 || wr_addr_q.size() - wb !== 0 || n_start - sb !== 0) begin
            miscompares++;
            $display("FAIL zero_activity: got reads=%0d writes=%0d starts=%0d want 0 0 0",
                     rd_addr_q.size() - rb, wr_addr_q.size() - wb, n_start - sb);
        end
    endtask

    task automatic test_len_clamp();
        int k, bl, wb;
        load_sweep();
        wb = wr_addr_q.size();
        start_run(5'd31, 16'h0001);
        wait_done(300, k, bl);
        vectors++;
        if (k !== 81) begin miscompares++; $display("FAIL clamp_done_cycle: got %0d want 81", k); end
        vectors++;
        if (wr_addr_q.size() - wb !== 16) begin
            miscompares++; $display("FAIL clamp_write_count: got %0d want 16", wr_addr_q.size() - wb);
        end else begin
            vectors++;
            if (wr_addr_q[wb+15] !== 4'hF || wr_data_q[wb+15] !== 16'h010E) begin
                miscompares++;
                $display("FAIL clamp_last_write: got addr=%h data=%h want f 010e", wr_addr_q[wb+15], wr_data_q[wb+15]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_ignored_start();
        int k, bl, wb, n;
        logic [DW-1:0] exp;
        for (int i = 0; i < 4; i++) begin
            wmem[i] = 16'h0200 + DW'(16 * i);
            gmem[i] = DW'(i + 1);
        end
        wb = wr_addr_q.size();
        start_run(5'd4, 16'h0005);
        @(negedge clk);
        sif.start_in = 1'b1;
        sif.len_in   = 5'd1;
        sif.lr_in    = 16'h0077;
        @(negedge clk);
        sif.start_in = 1'b0;
        vectors++;
        if (sif.gd_lr_out !== 16'h0005) begin miscompares++; $display("FAIL ign_lr_mid: got %h want 0005", sif.gd_lr_out); end
        wait_done(100, k, bl);
        vectors++;
        if (k !== 19) begin miscompares++; $display("FAIL ign_done_cycle: got %0d want 19", k); end
        n = wr_addr_q.size() - wb;
        vectors++;
        if (n !== 4) begin miscompares++; $display("FAIL ign_write_count: got %0d want 4", n); end
        for (int i = 0; i < n && i < 4; i++) begin
            exp = 16'h0200 + DW'(16 * i) - DW'(5 * (i + 1));
            vectors++;
            if (wr_data_q[wb+i] !== exp) begin
                miscompares++; $display("FAIL ign_write[%0d]: got %h want %h", i, wr_data_q[wb+i], exp);
            end
        end
        @(negedge clk);
        vectors++;
        if (sif.gd_lr_out !== 16'h0005 || sif.busy_out !== 1'b0) begin
            miscompares++; $display("FAIL ign_end: got lr=%h busy=%b want 0005 0", sif.gd_lr_out, sif.busy_out);
        end
    endtask

    task automatic test_reset_mid_run();
        int k, bl, wb, rb, sb, n, guard;
        bit hit5;
        load_sweep();
        gd_delay = 4;
        wb = wr_addr_q.size();
        sb = n_start;
        start_run(5'd8, 16'h0001);
        guard = 0;
        while (n_start - sb < 6 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (n_start - sb !== 6) begin miscompares++; $display("FAIL mid_reach_w5: got %0d starts want 6", n_start - sb); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({sif.rd_en_out, sif.gd_start_out, sif.wr_en_out, sif.busy_out, sif.done_out} !== 5'b0) begin
            miscompares++;
            $display("FAIL mid_reset_ctrl: got %b want 00000",
                     {sif.rd_en_out, sif.gd_start_out, sif.wr_en_out, sif.busy_out, sif.done_out});
        end
        vectors++;
        if ({sif.rd_addr_out, sif.wr_addr_out, sif.gd_lr_out, sif.gd_W_old_out, sif.gd_grad_out, sif.wr_data_out} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_data: got lr=%h wold=%h grad=%h wdata=%h addr=%h want all 0",
                     sif.gd_lr_out, sif.gd_W_old_out, sif.gd_grad_out, sif.wr_data_out, sif.rd_addr_out);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        gd_delay = 0;
        repeat (2) @(negedge clk);
        n = wr_addr_q.size() - wb;
        hit5 = 1'b0;
        for (int i = 0; i < n; i++) if (wr_addr_q[wb+i] == 4'd5) hit5 = 1'b1;
        vectors++;
        if (n !== 5 || hit5) begin
            miscompares++; $display("FAIL mid_no_write5: got %0d writes addr5_written=%b want 5 0", n, hit5);
        end
        wb = wr_addr_q.size();
        rb = rd_addr_q.size();
        start_run(5'd2, 16'h0001);
        wait_done(50, k, bl);
        vectors++;
        if (k !== 11) begin miscompares++; $display("FAIL mid_rerun_done: got %0d want 11", k); end
        vectors++;
        if (rd_addr_q.size() - rb !== 2 || wr_addr_q.size() - wb !== 2) begin
            miscompares++;
            $display("FAIL mid_rerun_count: got reads=%0d writes=%0d want 2 2", rd_addr_q.size() - rb, wr_addr_q.size() - wb);
        end else begin
            vectors++;
            if (rd_addr_q[rb] !== 4'd0 || wr_addr_q[wb] !== 4'd0 || wr_data_q[wb] !== 16'h00FF ||
                wr_addr_q[wb+1] !== 4'd1 || wr_data_q[wb+1] !== 16'h0100) begin
                miscompares++;
                $display("FAIL mid_rerun_writes: got rd0=%h w0=%h/%h w1=%h/%h want 0 0/00ff 1/0100",
                         rd_addr_q[rb], wr_addr_q[wb], wr_data_q[wb], wr_addr_q[wb+1], wr_data_q[wb+1]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_sweep();
        test_back_pressure();
        test_len_zero();
        test_len_clamp();
        test_ignored_start();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
